// File: rtl/dram_pkg.sv
// Shared types and helpers for the DRAM array controller.
// Row select is capped at MAX_ROWS word lines.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    REFRESH
  } dram_state_t;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;
  localparam int MAX_ROWS = 64;

  // Out-of-range index yields no selected row.
  function automatic logic [MAX_ROWS-1:0] onehot_row(
    input int idx,
    input int nrows
  );
    logic [MAX_ROWS-1:0] r;
    r = '0;
    if (idx >= 0 && idx < nrows && idx < MAX_ROWS)
      r = {{(MAX_ROWS-1){1'b0}}, 1'b1} << idx;
    return r;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
// Used by dram_ctrl when DRAM_CTRL_REFRESH_EN is defined.
module dram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_pending,
  output logic refresh_pending
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] cnt;
  logic          expire;

  assign expire = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= RELOAD;
      refresh_pending <= 1'b0;
    end else begin
      cnt <= expire ? RELOAD : cnt - 1'b1;
      // An expiry coinciding with a clear must not be lost.
      if (expire)
        refresh_pending <= 1'b1;
      else if (clear_pending)
        refresh_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Host-to-array DRAM controller: read/write sequencing and refresh sweep.
// Optional feature macro: DRAM_CTRL_REFRESH_EN (refresh timer + REFRESH state).
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int ROWS             = ROWS_DEF,
  parameter int COLS             = COLS_DEF,
  parameter int ADDR_W           = $clog2(ROWS),
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_rdata,
  output logic [ROWS-1:0]   word_line,
  output logic [COLS-1:0]   bit_line,
  output logic              read_en,
  output logic              write_en,
  output logic              refresh,
  input  logic [COLS-1:0]   data_in
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  dram_state_t       state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] row_q, row_n;
  logic [ROWS-1:0]   wl_n;
  logic [COLS-1:0]   bl_n;
  logic              ren_n, wen_n, ref_n;
  logic [COLS-1:0]   din_clean;
  logic              addr_oor;

  function automatic logic [ROWS-1:0] row_sel(input logic [ADDR_W-1:0] a);
    logic [MAX_ROWS-1:0] w;
    w = onehot_row(int'(a), ROWS);
    return w[ROWS-1:0];
  endfunction

`ifdef DRAM_CTRL_REFRESH_EN
  logic refresh_pending;
  logic clear_pending;

  dram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .clear_pending  (clear_pending),
    .refresh_pending(refresh_pending)
  );

  assign req_ready = (state == IDLE) && !refresh_pending;
`else
  assign req_ready = (state == IDLE);
`endif

  assign addr_oor = int'(addr_q) >= ROWS;

  // Undriven bus bits (X/Z) read back as 0.
  always_comb begin
    din_clean = '0;
    for (int i = 0; i < COLS; i++)
      din_clean[i] = (data_in[i] === 1'b1);
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    row_n   = row_q;
    wl_n    = '0;
    bl_n    = '0;
    ren_n   = 1'b0;
    wen_n   = 1'b0;
    ref_n   = 1'b0;
`ifdef DRAM_CTRL_REFRESH_EN
    clear_pending = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef DRAM_CTRL_REFRESH_EN
        if (refresh_pending) begin
          state_n       = REFRESH;
          row_n         = '0;
          clear_pending = 1'b1;
          wl_n          = row_sel('0);
          ref_n         = 1'b1;
        end else
`endif
        if (req_valid && req_ready) begin
          addr_n = req_addr;
          wl_n   = row_sel(req_addr);
          if (req_we) begin
            state_n = WRITE;
            bl_n    = req_wdata;
            wen_n   = 1'b1;
          end else begin
            state_n = READ;
            ren_n   = 1'b1;
          end
        end
      end
      WRITE: state_n = IDLE;
      READ:  state_n = IDLE;
`ifdef DRAM_CTRL_REFRESH_EN
      REFRESH: begin
        if (row_q == LAST_ROW) begin
          state_n = IDLE;
        end else begin
          row_n = row_q + 1'b1;
          wl_n  = row_sel(row_n);
          ref_n = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      row_q     <= '0;
      word_line <= '0;
      bit_line  <= '0;
      read_en   <= 1'b0;
      write_en  <= 1'b0;
      refresh   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      row_q     <= row_n;
      word_line <= wl_n;
      bit_line  <= bl_n;
      read_en   <= ren_n;
      write_en  <= wen_n;
      refresh   <= ref_n;
      rsp_valid <= (state == READ);
      if (state == READ)
        rsp_rdata <= addr_oor ? '0 : din_clean;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with behavioural cell arrays.
// Refresh checks are active when DRAM_CTRL_REFRESH_EN is defined.
module tb_dram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-row controller
  logic       req_valid, req_we, req_ready;
  logic [2:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata, word_line, bit_line, data_in;
  logic       rsp_valid, read_en, write_en, refresh;

  // 10-row controller for out-of-range addresses
  logic       b_valid, b_we, b_ready;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rdata, b_bl, b_din;
  logic [9:0] b_wl;
  logic       b_rsp, b_ren, b_wen, b_ref;

  dram_ctrl #(
    .ROWS(8), .COLS(8), .ADDR_W(3), .REFRESH_INTERVAL(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .word_line(word_line), .bit_line(bit_line),
    .read_en(read_en), .write_en(write_en), .refresh(refresh),
    .data_in(data_in)
  );

  dram_ctrl #(
    .ROWS(10), .COLS(8), .ADDR_W(4), .REFRESH_INTERVAL(64)
  ) dut10 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
    .word_line(b_wl), .bit_line(b_bl),
    .read_en(b_ren), .write_en(b_wen), .refresh(b_ref),
    .data_in(b_din)
  );

  // Cell arrays
  logic [7:0] mem8 [8];
  logic [7:0] mem10 [10];

  initial begin
    for (int i = 0; i < 8; i++) mem8[i] = 8'h00;
    for (int i = 0; i < 10; i++) mem10[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (write_en)
      for (int i = 0; i < 8; i++)
        if (word_line[i]) mem8[i] <= bit_line;
    if (b_wen)
      for (int i = 0; i < 10; i++)
        if (b_wl[i]) mem10[i] <= b_bl;
  end

  always_comb begin
    data_in = 8'h00;
    if (read_en)
      for (int i = 0; i < 8; i++)
        if (word_line[i]) data_in = mem8[i];
  end

  always_comb begin
    b_din = 8'h00;
    if (b_ren)
      for (int i = 0; i < 10; i++)
        if (b_wl[i]) b_din = mem10[i];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_bad = 0;

  always @(negedge clk)
    if (!rst && (int'(read_en) + int'(write_en) + int'(refresh)) > 1)
      strobe_bad++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req8(input logic we, input logic [2:0] a,
                      input logic [7:0] d, input logic [7:0] exp_wl,
                      input logic [7:0] exp_rd);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && t < 50) begin step(); t++; end
    chk("ready_wait", 32'(t < 50), 32'd1);
    step();
    req_valid = 1'b0;
    chk("word_line", 32'(word_line), 32'(exp_wl));
    chk(we ? "write_en" : "read_en", 32'(we ? write_en : read_en), 32'd1);
    chk("other_strobe", 32'({refresh, we ? read_en : write_en}), 32'd0);
    if (we) chk("bit_line", 32'(bit_line), 32'(d));
    chk("ready_busy", 32'(req_ready), 32'd0);
    step();
    chk("strobes_off", 32'({read_en, write_en, word_line}), 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(!we));
    if (!we) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
  endtask

  task automatic req10(input logic we, input logic [3:0] a,
                       input logic [7:0] d, input logic [9:0] exp_wl,
                       input logic [7:0] exp_rd);
    int t = 0;
    b_valid = 1'b1; b_we = we; b_addr = a; b_wdata = d;
    while (!b_ready && t < 50) begin step(); t++; end
    chk("r10_ready_wait", 32'(t < 50), 32'd1);
    step();
    b_valid = 1'b0;
    chk("r10_word_line", 32'(b_wl), 32'(exp_wl));
    step();
    if (!we) begin
      chk("r10_rsp_valid", 32'(b_rsp), 32'd1);
      chk("r10_rsp_rdata", 32'(b_rdata), 32'(exp_rd));
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_wl;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int bad_ref, bad_rdy;
    tbl[0] = '{1'b1, 3'd3, 8'hA5, 8'h08, 8'h00};
    tbl[1] = '{1'b0, 3'd3, 8'h00, 8'h08, 8'hA5};
    for (int r = 0; r < 8; r++) begin
      tbl[2+r]  = '{1'b1, 3'(r), 8'(r * 8'h11), 8'(1 << r), 8'h00};
      tbl[10+r] = '{1'b0, 3'(r), 8'h00, 8'(1 << r), 8'(r * 8'h11)};
    end

    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;

    // Reset state; a request during reset is ignored
    rst = 1'b1;
    step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'h5A;
    step();
    chk("rst_outputs",
        32'({word_line, bit_line, read_en, write_en, refresh, rsp_valid}),
        32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("no_write_in_rst", 32'(mem8[1]), 32'd0);

    for (int i = 0; i < 18; i++)
      req8(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_wl,
           tbl[i].exp_rd);

    // Reset during the READ cycle aborts the response
    begin
      int t = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
      while (!req_ready && t < 50) begin step(); t++; end
      step();
      req_valid = 1'b0;
      chk("abort_read_en", 32'(read_en), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_strobes",
          32'({word_line, read_en, write_en, refresh}), 32'd0);
    end

`ifdef DRAM_CTRL_REFRESH_EN
    // Timer restarts from 15: pending appears on the 16th edge
    for (int i = 0; i < 15; i++) step();
    chk("timer_not_yet", 32'(req_ready), 32'd1);
    step();
    chk("timer_expired", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
    step();
    for (int r = 0; r < 8; r++) begin
      chk("ref_word_line", 32'(word_line), 32'(1 << r));
      chk("ref_strobe", 32'({refresh, read_en, req_ready}), 32'b100);
      step();
    end
    chk("ref_done", 32'({refresh, req_ready}), 32'b01);
    step();
    req_valid = 1'b0;
    chk("held_read_en", 32'({read_en, word_line}), 32'h108);
    step();
    chk("held_rsp", 32'({rsp_valid, rsp_rdata}), 32'h133);
`else
    bad_ref = 0; bad_rdy = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (refresh !== 1'b0) bad_ref++;
      if (req_ready !== 1'b1) bad_rdy++;
    end
    chk("idle_refresh_cycles", 32'(bad_ref), 32'd0);
    chk("idle_not_ready_cycles", 32'(bad_rdy), 32'd0);
`endif

    // Out-of-range rows on the 10-row controller
    for (int r = 0; r < 9; r++)
      req10(1'b1, 4'(r), 8'hFF, 10'(1 << r), 8'h00);
    req10(1'b1, 4'd12, 8'hFF, 10'h000, 8'h00);
    req10(1'b0, 4'd8, 8'h00, 10'h100, 8'hFF);
    req10(1'b0, 4'd9, 8'h00, 10'h200, 8'h00);
    for (int a = 10; a < 16; a++)
      req10(1'b0, 4'(a), 8'h00, 10'h000, 8'h00);

    chk("strobe_exclusive", 32'(strobe_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
